// File: rtl/btb_update_queue.sv
// btb_update_queue: buffers resolved-taken branches and drains them one per cycle into the BTB write port
module btb_update_queue #(
  parameter int DEPTH = 8,
  parameter int NUM_IN = 2,
  parameter int ADDR = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_IN-1:0]            in_valid,
  input  logic [NUM_IN-1:0]            in_taken,
  input  logic [NUM_IN*ADDR-1:0]       in_pc,
  input  logic [NUM_IN*ADDR-1:0]       in_target,
  output logic                         in_ready,
  input  logic                         wr_hold,
  output logic                         btb_wr_en,
  output logic [ADDR-1:0]              btb_wr_pc,
  output logic [ADDR-1:0]              btb_wr_target,
  output logic                         drop,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [ADDR-1:0] pc_q [DEPTH];
  logic [ADDR-1:0] pc_d [DEPTH];
  logic [ADDR-1:0] tgt_q [DEPTH];
  logic [ADDR-1:0] tgt_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, n;
  logic last_v_q, last_v_d;
  logic [ADDR-1:0] last_pc_q, last_pc_d, last_tgt_q, last_tgt_d;
  logic [NUM_IN-1:0] elig, surv;
  assign count = count_q;
  assign in_ready = count_q <= CW'(DEPTH - NUM_IN);
  assign btb_wr_en = (count_q != '0) & ~wr_hold;
  assign btb_wr_pc = btb_wr_en ? pc_q[head_q] : '0;
  assign btb_wr_target = btb_wr_en ? tgt_q[head_q] : '0;
  assign drop = ~in_ready & |surv;
  always_comb begin
    elig = in_valid & in_taken & {NUM_IN{~reset}};
    surv = elig;
    for (int i = 0; i < NUM_IN; i++) begin
      if (last_v_q && in_pc[i*ADDR +: ADDR] == last_pc_q && in_target[i*ADDR +: ADDR] == last_tgt_q)
        surv[i] = 1'b0;
      for (int j = 0; j < i; j++)
        if (elig[j] && in_pc[j*ADDR +: ADDR] == in_pc[i*ADDR +: ADDR] && in_target[j*ADDR +: ADDR] == in_target[i*ADDR +: ADDR])
          surv[i] = 1'b0;
    end
  end
  always_comb begin
    pc_d = pc_q;
    tgt_d = tgt_q;
    last_v_d = last_v_q;
    last_pc_d = last_pc_q;
    last_tgt_d = last_tgt_q;
    n = '0;
    for (int i = 0; i < NUM_IN; i++)
      if (in_ready && surv[i]) begin
        pc_d[tail_q + PW'(n)] = in_pc[i*ADDR +: ADDR];
        tgt_d[tail_q + PW'(n)] = in_target[i*ADDR +: ADDR];
        last_v_d = 1'b1;
        last_pc_d = in_pc[i*ADDR +: ADDR];
        last_tgt_d = in_target[i*ADDR +: ADDR];
        n = n + CW'(1);
      end
    head_d = head_q + PW'(btb_wr_en);
    tail_d = tail_q + PW'(n);
    count_d = count_q + n - CW'(btb_wr_en);
  end
  always_ff @(posedge clock) begin
    pc_q <= pc_d;
    tgt_q <= tgt_d;
    if (reset) begin
      count_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      last_v_q <= 1'b0;
      last_pc_q <= '0;
      last_tgt_q <= '0;
    end else begin
      count_q <= count_d;
      head_q <= head_d;
      tail_q <= tail_d;
      last_v_q <= last_v_d;
      last_pc_q <= last_pc_d;
      last_tgt_q <= last_tgt_d;
    end
  end
endmodule
